// File: rtl/mem_store_rmw.sv
// Read-modify-write store unit: merges sub-word store data into a memory word through a
// single-port request/grant memory interface, skipping the read for full-width stores.
module mem_store_rmw #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam logic [1:0]  FullSize = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;

  typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [NumBytes-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic [OffW-1:0]       off;
  logic [NumBytes-1:0]   size_mask;
  logic [2:0]            align_mask;
  logic                  reject;
  logic [DATA_WIDTH-1:0] merged;

  assign off = req_addr[OffW-1:0];

  always_comb begin
    size_mask  = '1;
    align_mask = 3'd7;
    case (req_size)
      2'd0: begin size_mask = NumBytes'(1);  align_mask = 3'd0; end
      2'd1: begin size_mask = NumBytes'(3);  align_mask = 3'd1; end
      2'd2: begin size_mask = NumBytes'(15); align_mask = 3'd3; end
      default: begin size_mask = '1;         align_mask = 3'd7; end
    endcase
  end

  assign reject = ((req_size == 2'd3) && (DATA_WIDTH == 32)) || (|(req_addr[2:0] & align_mask));

  // Store data and byte enables are pre-shifted into their lanes at acceptance.
  always_comb begin
    merged = mem_rdata;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      if (be_q[b]) merged[8*b +: 8] = sdata_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = {req_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
          sdata_d = req_wdata << {off, 3'b000};
          be_d    = size_mask << off;
          err_d   = reject;
          if (reject) begin
            state_d = StResp;
          end else if (req_size == FullSize) begin
            wdata_d = req_wdata;
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:     if (mem_gnt) state_d = StRdWait;
      StRdWait: begin
        if (mem_rvalid) begin
          wdata_d = merged;
          state_d = StWr;
        end
      end
      StWr:     if (mem_gnt) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      sdata_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = (state_q == StResp) && err_q;
  assign mem_req   = (state_q == StRd) || (state_q == StWr);
  assign mem_we    = (state_q == StWr);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
